// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
// Pure declarations: no latency, no backpressure.
package mem_port_arbiter_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;
   localparam int WDOG_W = 10;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
   typedef enum logic {GRANT_I, GRANT_D} grant_t;

   // A tie goes to the port that did not win last time.
   function automatic grant_t pick_grant(input logic req_i, input logic req_d, input grant_t last);
      if (req_i && req_d)
         return (last == GRANT_I) ? GRANT_D : GRANT_I;
      return req_d ? GRANT_D : GRANT_I;
   endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and shared memory bus of the arbiter.
// master = arbiter side, slave = requesters plus memory side.
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ack;
   logic              i_err;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [STRB_W-1:0] d_wstrb;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   logic              d_err;

   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [STRB_W-1:0] m_wstrb;
   logic [DATA_W-1:0] m_rdata;
   logic              m_ack;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata, m_ack,
      output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
      output m_req, m_we, m_addr, m_wdata, m_wstrb
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata, m_ack,
      input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
      input  m_req, m_we, m_addr, m_wdata, m_wstrb
   );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Counts busy cycles without m_ack; expired is combinational in the TIMEOUT-th such cycle.
// Clear has priority over enable.
module bus_watchdog
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   logic [WDOG_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else if (clear_i)
         cnt_q <= '0;
      else if (enable_i)
         cnt_q <= cnt_q + WDOG_W'(1);
   end

   assign expired_o = enable_i && (cnt_q == WDOG_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one registered memory bus; grant to m_req in 1 cycle,
// ack combinational with m_ack, back-to-back re-grant, watchdog abort after TIMEOUT cycles.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.master  bus
);
   arb_state_t        state_q, state_d;
   grant_t            last_q, last_d;
   logic              m_req_q;
   logic              m_we_q, m_we_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic [STRB_W-1:0] m_wstrb_q, m_wstrb_d;

   logic              grant_vld;
   grant_t            grant_sel;
   logic              wd_en, wd_expired;
   logic              i_ack, i_err, d_ack, d_err;
   logic [DATA_W-1:0] i_rdata, d_rdata;

   assign wd_en = (state_q != IDLE) && !bus.m_ack;

   bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (grant_vld),
      .enable_i  (wd_en),
      .expired_o (wd_expired)
   );

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_wstrb_d = m_wstrb_q;
      grant_vld = 1'b0;
      grant_sel = GRANT_I;
      i_ack     = 1'b0;
      i_err     = 1'b0;
      i_rdata   = '0;
      d_ack     = 1'b0;
      d_err     = 1'b0;
      d_rdata   = '0;

      // wd_expired is masked by m_ack, so a same-cycle ack always completes cleanly.
      case (state_q)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               grant_vld = 1'b1;
               grant_sel = pick_grant(bus.i_req, bus.d_req, last_q);
            end
         end
         BUSY_I: begin
            if (bus.m_ack || wd_expired) begin
               i_ack   = 1'b1;
               i_err   = !bus.m_ack;
               i_rdata = bus.m_ack ? bus.m_rdata : '0;
               last_d  = GRANT_I;
               state_d = IDLE;
               if (bus.d_req) begin
                  grant_vld = 1'b1;
                  grant_sel = GRANT_D;
               end
            end
         end
         BUSY_D: begin
            if (bus.m_ack || wd_expired) begin
               d_ack   = 1'b1;
               d_err   = !bus.m_ack;
               d_rdata = bus.m_ack ? bus.m_rdata : '0;
               last_d  = GRANT_D;
               state_d = IDLE;
               if (bus.i_req) begin
                  grant_vld = 1'b1;
                  grant_sel = GRANT_I;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant_vld) begin
         if (grant_sel == GRANT_D) begin
            state_d   = BUSY_D;
            m_we_d    = bus.d_we;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
            m_wstrb_d = bus.d_wstrb;
         end else begin
            state_d   = BUSY_I;
            m_we_d    = 1'b0;
            m_addr_d  = bus.i_addr;
            m_wdata_d = '0;
            m_wstrb_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         last_q    <= GRANT_I;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_wstrb_q <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         m_req_q   <= (state_d != IDLE);
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_wstrb_q <= m_wstrb_d;
      end
   end

   assign bus.m_req   = m_req_q;
   assign bus.m_we    = m_we_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;
   assign bus.m_wstrb = m_wstrb_q;
   assign bus.i_ack   = i_ack;
   assign bus.i_err   = i_err;
   assign bus.i_rdata = i_rdata;
   assign bus.d_ack   = d_ack;
   assign bus.d_err   = d_err;
   assign bus.d_rdata = d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed stimulus for mem_port_arbiter; expected acks are queued and checked by a monitor.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;

   mem_port_arbiter_if bus_if();

   mem_port_arbiter #(.TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic is_d, input logic [31:0] rdata, input logic err, input int c);
      exp_q.push_back('{is_d: is_d, rdata: rdata, err: err, cyc: c});
   endtask

   // Monitor: every ack must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset) begin
         chk("ack_exclusive", {31'b0, bus_if.i_ack & bus_if.d_ack}, 32'd0);
         if (bus_if.i_ack || bus_if.d_ack) begin
            if (exp_q.size() == 0) begin
               chk("ack_expected", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               chk("ack_port_d", {31'b0, bus_if.d_ack}, {31'b0, e.is_d});
               chk("ack_cycle", 32'(cyc), 32'(e.cyc));
               chk("ack_rdata", e.is_d ? bus_if.d_rdata : bus_if.i_rdata, e.rdata);
               chk("ack_err", {31'b0, e.is_d ? bus_if.d_err : bus_if.i_err}, {31'b0, e.err});
            end
         end
      end
   end

   // Both ports request together; each is acked in its first busy cycle.
   task automatic tie_pair(input logic first_d);
      int c;
      c = cyc;
      bus_if.i_req  = 1'b1;
      bus_if.i_addr = 32'h200;
      bus_if.d_req  = 1'b1;
      bus_if.d_we   = 1'b0;
      bus_if.d_addr = 32'h300;
      push(first_d, 32'hA1, 1'b0, c + 1);
      push(!first_d, 32'hB2, 1'b0, c + 2);
      step();
      bus_if.m_ack   = 1'b1;
      bus_if.m_rdata = 32'hA1;
      @(negedge clk);
      chk("tie_first_addr", bus_if.m_addr, first_d ? 32'h300 : 32'h200);
      step();
      if (first_d) bus_if.d_req = 1'b0;
      else         bus_if.i_req = 1'b0;
      bus_if.m_rdata = 32'hB2;
      @(negedge clk);
      chk("tie_b2b_m_req", {31'b0, bus_if.m_req}, 32'd1);
      chk("tie_second_addr", bus_if.m_addr, first_d ? 32'h200 : 32'h300);
      step();
      bus_if.m_ack = 1'b0;
      bus_if.i_req = 1'b0;
      bus_if.d_req = 1'b0;
      @(negedge clk);
      chk("tie_idle_m_req", {31'b0, bus_if.m_req}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "time limit");
   end

   initial begin
      int c;
      reset          = 1'b1;
      bus_if.i_req   = 1'b0;
      bus_if.i_addr  = '0;
      bus_if.d_req   = 1'b0;
      bus_if.d_we    = 1'b0;
      bus_if.d_addr  = '0;
      bus_if.d_wdata = '0;
      bus_if.d_wstrb = '0;
      bus_if.m_rdata = '0;
      bus_if.m_ack   = 1'b0;
      step();
      step();
      chk("rst_m_req", {31'b0, bus_if.m_req}, 32'd0);
      chk("rst_m_addr", bus_if.m_addr, 32'd0);
      chk("rst_acks", {30'b0, bus_if.i_ack, bus_if.d_ack}, 32'd0);
      reset = 1'b0;
      step();

      // Store through the data port, acked in the third busy cycle.
      c = cyc;
      bus_if.d_req   = 1'b1;
      bus_if.d_we    = 1'b1;
      bus_if.d_addr  = 32'h100;
      bus_if.d_wdata = 32'hDEADBEEF;
      bus_if.d_wstrb = 4'hF;
      push(1'b1, 32'h55, 1'b0, c + 3);
      @(negedge clk);
      chk("st_m_req_c0", {31'b0, bus_if.m_req}, 32'd0);
      step();
      @(negedge clk);
      chk("st_m_req_c1", {31'b0, bus_if.m_req}, 32'd1);
      chk("st_m_addr", bus_if.m_addr, 32'h100);
      chk("st_m_we", {31'b0, bus_if.m_we}, 32'd1);
      chk("st_m_wdata", bus_if.m_wdata, 32'hDEADBEEF);
      chk("st_m_wstrb", {28'b0, bus_if.m_wstrb}, 32'hF);
      step();
      @(negedge clk);
      chk("st_m_req_c2", {31'b0, bus_if.m_req}, 32'd1);
      step();
      bus_if.m_ack   = 1'b1;
      bus_if.m_rdata = 32'h55;
      @(negedge clk);
      chk("st_m_req_c3", {31'b0, bus_if.m_req}, 32'd1);
      step();
      bus_if.m_ack = 1'b0;
      bus_if.d_req = 1'b0;
      @(negedge clk);
      chk("st_idle", {31'b0, bus_if.m_req}, 32'd0);

      // Fetch acked in its first busy cycle; payload must be zeroed for fetches.
      c = cyc;
      bus_if.i_req  = 1'b1;
      bus_if.i_addr = 32'h40;
      push(1'b0, 32'h13, 1'b0, c + 1);
      step();
      bus_if.m_ack   = 1'b1;
      bus_if.m_rdata = 32'h13;
      @(negedge clk);
      chk("if_m_addr", bus_if.m_addr, 32'h40);
      chk("if_m_we", {31'b0, bus_if.m_we}, 32'd0);
      chk("if_m_wdata", bus_if.m_wdata, 32'd0);
      chk("if_m_wstrb", {28'b0, bus_if.m_wstrb}, 32'd0);
      step();
      bus_if.m_ack = 1'b0;
      bus_if.i_req = 1'b0;
      @(negedge clk);
      chk("if_idle", {31'b0, bus_if.m_req}, 32'd0);

      // Fresh reset: first tie goes to D, then I; next tie again D (I won last).
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      tie_pair(1'b1);
      tie_pair(1'b1);

      // Data load with no m_ack times out after 4 busy cycles.
      c = cyc;
      bus_if.d_req   = 1'b1;
      bus_if.d_we    = 1'b0;
      bus_if.d_addr  = 32'h80;
      bus_if.m_rdata = 32'hFFFFFFFF;
      push(1'b1, 32'h0, 1'b1, c + 4);
      repeat (4) step();
      @(negedge clk);
      chk("to_m_req_c4", {31'b0, bus_if.m_req}, 32'd1);
      step();
      bus_if.d_req = 1'b0;
      @(negedge clk);
      chk("to_idle", {31'b0, bus_if.m_req}, 32'd0);
      step();

      // m_ack in the 4th busy cycle beats the timeout.
      c = cyc;
      bus_if.d_req = 1'b1;
      push(1'b1, 32'h77, 1'b0, c + 4);
      repeat (4) step();
      bus_if.m_ack   = 1'b1;
      bus_if.m_rdata = 32'h77;
      step();
      bus_if.m_ack = 1'b0;
      bus_if.d_req = 1'b0;
      step();

      // Last grant was D; a tie now goes to I.
      tie_pair(1'b0);

      // One more D-only so that last grant is D before the reset test.
      c = cyc;
      bus_if.d_req = 1'b1;
      push(1'b1, 32'h3C, 1'b0, c + 1);
      step();
      bus_if.m_ack   = 1'b1;
      bus_if.m_rdata = 32'h3C;
      step();
      bus_if.m_ack = 1'b0;
      bus_if.d_req = 1'b0;
      step();

      // Asynchronous reset in the middle of a data transfer.
      bus_if.d_req  = 1'b1;
      bus_if.d_addr = 32'h400;
      step();
      @(negedge clk);
      chk("rb_m_req_busy", {31'b0, bus_if.m_req}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rb_m_req_async", {31'b0, bus_if.m_req}, 32'd0);
      chk("rb_m_addr_async", bus_if.m_addr, 32'd0);
      chk("rb_d_ack", {31'b0, bus_if.d_ack}, 32'd0);
      bus_if.d_req = 1'b0;
      step();
      reset = 1'b0;
      step();
      tie_pair(1'b1);

      // m_ack while idle is ignored.
      bus_if.m_ack   = 1'b1;
      bus_if.m_rdata = 32'h99;
      @(negedge clk);
      chk("idle_ack_acks", {30'b0, bus_if.i_ack, bus_if.d_ack}, 32'd0);
      chk("idle_ack_m_req", {31'b0, bus_if.m_req}, 32'd0);
      step();
      bus_if.m_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_stay", {31'b0, bus_if.m_req}, 32'd0);
      step();

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 255, max cycles a bus transfer may wait for m_ack before being aborted (range 1..1023).
REQ-002 SHALL have one clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 i_req  in  1  instruction-fetch request, held until i_ack.
REQ-006 i_addr  in  32  fetch address, stable while i_req.
REQ-007 i_rdata  out  32  fetch data, valid with i_ack.
REQ-008 i_ack  out  1  one-cycle fetch completion pulse.
REQ-009 i_err  out  1  fetch timed out, coincident with i_ack.
REQ-010 d_req  in  1  data-port request (load/store), held until d_ack.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  32  data address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_wstrb  in  4  store byte enables.
REQ-015 d_rdata  out  32  load data, valid with d_ack.
REQ-016 d_ack  out  1  one-cycle data completion pulse.
REQ-017 d_err  out  1  data access timed out, coincident with d_ack.
REQ-018 m_req / m_we / m_addr / m_wdata / m_wstrb  out  1/1/32/32/4  shared memory bus request and payload, all registered.
REQ-019 m_rdata  in  32  bus read data, valid with m_ack.
REQ-020 m_ack  in  1  bus completion pulse.

Function
REQ-021 FSM states IDLE, BUSY_I, BUSY_D; m_req SHALL be 1 exactly when state is BUSY_I or BUSY_D.
REQ-022 IDLE: i_req only -> BUSY_I; d_req only -> BUSY_D; both -> grant the port not granted last (last_grant pointer); neither -> stay.
REQ-023 Grant SHALL latch the winner's address, we, wdata, wstrb into m_* registers; instruction grant drives m_we=0, m_wstrb=0, m_wdata=0.
REQ-024 Latency: request seen in IDLE at cycle N -> m_req=1 at cycle N+1; m_* SHALL stay constant while BUSY.
REQ-025 On m_ack in BUSY_x: x_ack=1 and x_rdata=m_rdata combinationally in that cycle; last_grant <= x.
REQ-026 Same cycle as m_ack, re-arbitration SHALL ignore the just-acked port: other port requesting -> go directly to its BUSY state (back-to-back, no idle cycle); else -> IDLE.
REQ-027 Watchdog counter SHALL clear on entering BUSY and increment each BUSY cycle without m_ack; reaching TIMEOUT -> x_ack=1, x_err=1, x_rdata=0, transition as REQ-026.
REQ-028 m_ack and timeout in the same cycle: m_ack wins, err=0.
REQ-029 m_ack while IDLE SHALL be ignored (no ack, no state change).
REQ-030 Requests dropped without ack are protocol violations; no recovery required.
REQ-031 i_ack and d_ack SHALL never be 1 in the same cycle.

Reset
REQ-032 reset asserted (any cycle, incl. mid-transfer): state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, m_wstrb=0, watchdog=0, last_grant=I (data wins first tie), all ack/err outputs 0, immediately and asynchronously.

Structure
REQ-033 Shared package SHALL hold arb_state_t (IDLE, BUSY_I, BUSY_D), grant enum (GRANT_I, GRANT_D), and bus width constants.
REQ-034 Watchdog SHALL be a sub-module bus_watchdog (clear, enable, TIMEOUT parameter, expired output).

Verification
REQ-035 d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF at cycle 0; m_ack at cycle 3 -> m_req 1 in cycles 1-3, m_addr=0x100, d_ack=1 cycle 3, i_ack never.
REQ-036 i_req and d_req both at cycle 0 after reset, m_ack after 2 cycles each -> D served first, I follows back-to-back (m_req stays 1), then another tie -> I is not preferred over... pointer alternates: next tie grants D after I.
REQ-037 i_req only, addr 0x40, m_rdata=0x00000013 with m_ack cycle 1 -> i_rdata=0x13, i_ack=1 cycle 1, IDLE cycle 2.
REQ-038 TIMEOUT=4, d_req load, no m_ack -> d_ack=1, d_err=1, d_rdata=0 after 4 BUSY cycles; m_ack arriving in 4th cycle instead -> d_err=0.
REQ-039 reset pulsed during BUSY_D -> m_req=0 same cycle, no d_ack; after release tie grants D.
REQ-040 m_ack pulsed while IDLE -> no i_ack/d_ack, state unchanged.
